// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate engine.
// Streams signed activations, multiplies each by a weight from an internal
// RAM and accumulates the products (with saturation) on top of a bias.
// A completed frame's sum is presented with a one-cycle sum_valid pulse.
module neuron_mac #(
  parameter int data_width       = 16,
  parameter int weight_int_width = 4,
  parameter int num_inputs       = 784,
  parameter int addr_width       = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      w_wen,
  input  logic [addr_width-1:0]     w_addr,
  input  logic [data_width-1:0]     w_data,
  input  logic                      b_wen,
  input  logic [2*data_width-1:0]   b_data,
  input  logic                      in_valid,
  input  logic [data_width-1:0]     in_data,
  output logic                      busy,
  output logic                      sum_valid,
  output logic [2*data_width-1:0]   sum
);

  localparam int pw = 2 * data_width;
  localparam logic [addr_width-1:0] last_idx = addr_width'(num_inputs - 1);
  localparam logic [addr_width:0]   depth    = (addr_width + 1)'(num_inputs);
  localparam logic [pw-1:0]         pos_max  = {1'b0, {(pw-1){1'b1}}};
  localparam logic [pw-1:0]         neg_min  = {1'b1, {(pw-1){1'b0}}};

  // Elaboration-time sanity checks on the parameter set. The sum's top
  // weight_int_width+1 bits carry sign+integer for the downstream stage,
  // so that field has to fit inside the product word.
  if (num_inputs < 2) begin : g_bad_fanin
    $error("neuron_mac: num_inputs must be >= 2");
  end
  if ((64'd1 << addr_width) < 64'(num_inputs)) begin : g_bad_addr
    $error("neuron_mac: addr_width too small for num_inputs");
  end
  if (weight_int_width + 1 > pw) begin : g_bad_fmt
    $error("neuron_mac: weight_int_width does not fit the sum format");
  end

  logic signed [data_width-1:0] mem [num_inputs];

  logic [addr_width-1:0]        cnt_reg;

  logic                         s1_valid_reg, s1_first_reg, s1_last_reg;
  logic signed [data_width-1:0] s1_data_reg;
  logic signed [data_width-1:0] s1_weight_reg;

  logic                         s2_valid_reg, s2_first_reg, s2_last_reg;
  logic signed [pw-1:0]         s2_prod_reg;

  logic                         s3_valid_reg;
  logic signed [pw-1:0]         acc_reg;
  logic signed [pw-1:0]         bias_reg;
  logic signed [pw-1:0]         sum_reg;
  logic                         sum_valid_reg;

  logic signed [pw-1:0]         acc_base;
  logic signed [pw-1:0]         add_raw;
  logic                         add_ovf;
  logic signed [pw-1:0]         acc_next;

  // Weight RAM: write port plus registered read addressed by the beat counter.
  // The read register is the S1 weight, captured on the same edge as the beat.
  always_ff @(posedge clk) begin
    if (w_wen && ({1'b0, w_addr} < depth)) begin
      mem[w_addr] <= w_data;
    end
    s1_weight_reg <= mem[cnt_reg];
  end

  // Beat counter: advances per accepted beat and wraps after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (in_valid) begin
      cnt_reg <= (cnt_reg == last_idx) ? '0 : cnt_reg + 1'b1;
    end
  end

  // S1: capture activation and first/last tags for the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      s1_first_reg <= in_valid && (cnt_reg == '0);
      s1_last_reg  <= in_valid && (cnt_reg == last_idx);
      s1_data_reg  <= in_data;
    end
  end

  // S2: full-width signed product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_first_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_prod_reg  <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_first_reg <= s1_first_reg;
      s2_last_reg  <= s1_last_reg;
      s2_prod_reg  <= s1_data_reg * s1_weight_reg;
    end
  end

  // S3 adder: a first beat starts from the bias, others from the accumulator;
  // same-sign operands producing a different-sign result clamp to the rail.
  always_comb begin
    acc_base = s2_first_reg ? bias_reg : acc_reg;
    add_raw  = acc_base + s2_prod_reg;
    add_ovf  = (acc_base[pw-1] == s2_prod_reg[pw-1]) &&
               (add_raw[pw-1] != acc_base[pw-1]);
    acc_next = add_raw;
    if (add_ovf) begin
      acc_next = acc_base[pw-1] ? neg_min : pos_max;
    end
  end

  // S3 state: accumulator update and frame result on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_reg  <= 1'b0;
      acc_reg       <= '0;
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
    end else begin
      s3_valid_reg  <= s2_valid_reg;
      sum_valid_reg <= s2_valid_reg && s2_last_reg;
      if (s2_valid_reg) begin
        acc_reg <= acc_next;
      end
      if (s2_valid_reg && s2_last_reg) begin
        sum_reg <= acc_next;
      end
    end
  end

  // Bias register; a first beat in S3 on the same edge still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_reg <= '0;
    end else if (b_wen) begin
      bias_reg <= b_data;
    end
  end

  assign busy      = (cnt_reg != '0) || s1_valid_reg || s2_valid_reg || s3_valid_reg;
  assign sum_valid = sum_valid_reg;
  assign sum       = sum_reg;

endmodule
